// File: rtl/adc_j_averager.sv
`default_nettype none
// ============================================================================
//  Module   : adc_j_averager
//  Purpose  : Front end for the JP/JM capture registers. On a single-cycle
//             trigger it waits SETTLE_CYCLES for the dithered DAC outputs to
//             settle. It then averages 2^LOG2_N consecutive ADC samples and
//             presents the mean metric J with a one-cycle valid strobe.
//  Ports    : clk         ADC sample clock (only clock)
//             rst_n       asynchronous active-low reset
//             i_trig      single-cycle start pulse
//             i_abort     synchronous abort, discards the partial sum
//             i_clr_ovr   synchronous clear of o_overrun
//             i_adc       raw ADC sample, one per cycle
//             o_j         last completed average, held until next completion
//             o_j_valid   one-cycle strobe: o_j updated this cycle
//             o_busy      high in SETTLE, ACCUM or DONE
//             o_overrun   sticky: trigger arrived while not IDLE
//             o_state     FSM state (IDLE=0, SETTLE=1, ACCUM=2, DONE=3)
//  Config   : J_AVG_TWOS_COMP_EN - when defined, i_adc is two's complement
//             and is converted to offset binary (MSB inverted) before
//             accumulation. When undefined, i_adc is accumulated as-is.
//  Revision : 1.0  initial release
// ============================================================================
module adc_j_averager #(
    parameter int ADC_WIDTH     = 12,
    parameter int LOG2_N        = 4,
    parameter int SETTLE_CYCLES = 625,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_trig,
    input  logic                 i_abort,
    input  logic                 i_clr_ovr,
    input  logic [ADC_WIDTH-1:0] i_adc,
    output logic [ADC_WIDTH-1:0] o_j,
    output logic                 o_j_valid,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic [1:0]           o_state
);

    // Accumulator is wide enough that N full-scale samples cannot wrap.
    localparam int ACC_W = ADC_WIDTH + LOG2_N;

    localparam logic [CNT_WIDTH-1:0] C_SETTLE_LAST =
        CNT_WIDTH'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [CNT_WIDTH-1:0] C_N_LAST = CNT_WIDTH'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [ACC_W-1:0]       r_acc;
    logic [ADC_WIDTH-1:0]   r_j;
    logic                   r_j_valid;
    logic                   r_busy;
    logic                   r_overrun;
    logic [ADC_WIDTH-1:0]   w_sample;

`ifdef J_AVG_TWOS_COMP_EN
    // Offset-binary conversion: mid-scale of the signed input maps to 2^(W-1).
    assign w_sample = {~i_adc[ADC_WIDTH-1], i_adc[ADC_WIDTH-2:0]};
`else
    assign w_sample = i_adc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_j       <= '0;
            r_j_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_j_valid <= 1'b0;

            // A new overrun takes priority over a simultaneous clear. A trigger
            // in the DONE cycle is an overrun because the state is not IDLE.
            if (i_trig && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end

            if (i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_trig) begin
                            r_cnt  <= '0;
                            r_acc  <= '0;
                            r_busy <= 1'b1;
                            if (SETTLE_CYCLES == 0) begin
                                r_state <= S_ACCUM;
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == C_SETTLE_LAST) begin
                            r_state <= S_ACCUM;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_ACCUM: begin
                        r_acc <= r_acc + ACC_W'(w_sample);
                        if (r_cnt == C_N_LAST) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        // Truncating divide by N.
                        r_j       <= r_acc[ACC_W-1:LOG2_N];
                        r_j_valid <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_j       = r_j;
    assign o_j_valid = r_j_valid;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;
    assign o_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_adc_j_averager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_j_averager
//  Purpose  : Directed bench for adc_j_averager. Three instances:
//             A (SETTLE=4, LOG2_N=2), B (SETTLE=4, LOG2_N=8),
//             C (SETTLE=0, LOG2_N=0). Expected values are hand-derived.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_j_averager;

    logic        clk;
    logic        rst_n;
    logic [11:0] adc;
    logic        trig_a, trig_b, trig_c;
    logic        abort_a, clr_a;

    logic [11:0] j_a, j_b, j_c;
    logic        val_a, val_b, val_c;
    logic        busy_a, busy_b, busy_c;
    logic        ovr_a, ovr_b, ovr_c;
    logic [1:0]  st_a, st_b, st_c;

    int n_chk  = 0;
    int n_pass = 0;

    adc_j_averager #(.ADC_WIDTH(12), .LOG2_N(2), .SETTLE_CYCLES(4), .CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_trig(trig_a), .i_abort(abort_a), .i_clr_ovr(clr_a),
        .i_adc(adc), .o_j(j_a), .o_j_valid(val_a), .o_busy(busy_a), .o_overrun(ovr_a),
        .o_state(st_a));

    adc_j_averager #(.ADC_WIDTH(12), .LOG2_N(8), .SETTLE_CYCLES(4), .CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_trig(trig_b), .i_abort(1'b0), .i_clr_ovr(1'b0),
        .i_adc(adc), .o_j(j_b), .o_j_valid(val_b), .o_busy(busy_b), .o_overrun(ovr_b),
        .o_state(st_b));

    adc_j_averager #(.ADC_WIDTH(12), .LOG2_N(0), .SETTLE_CYCLES(0), .CNT_WIDTH(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .i_trig(trig_c), .i_abort(1'b0), .i_clr_ovr(1'b0),
        .i_adc(adc), .o_j(j_c), .o_j_valid(val_c), .o_busy(busy_c), .o_overrun(ovr_c),
        .o_state(st_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sample value as seen by the accumulator.
    function automatic logic [11:0] conv(input logic [11:0] x);
`ifdef J_AVG_TWOS_COMP_EN
        return x ^ 12'h800;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected instance's valid is seen; lat = edges counted, -1 on timeout.
    task automatic wait_valid(input int which, input int budget, output int lat);
        logic v;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            case (which)
                0: v = val_a;
                1: v = val_b;
                default: v = val_c;
            endcase
            if (v) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic start_a();
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
    endtask

    int          lat;
    logic        seen;
    logic [13:0] sum;

    initial begin
        rst_n = 1'b0; adc = 12'h000;
        trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0;
        abort_a = 1'b0; clr_a = 1'b0;
        tick(); tick();
        chk("rst_j",     32'(j_a),    32'h0);
        chk("rst_valid", 32'(val_a),  32'h0);
        chk("rst_busy",  32'(busy_a), 32'h0);
        chk("rst_ovr",   32'(ovr_a),  32'h0);
        chk("rst_state", 32'(st_a),   32'h0);
        rst_n = 1'b1;
        tick();

        // Constant input: latency SETTLE+N+1 = 9 edges.
        adc = 12'h400;
        start_a();
        chk("s1_state_settle", 32'(st_a),   32'd1);
        chk("s1_busy",         32'(busy_a), 32'd1);
        wait_valid(0, 20, lat);
        chk("s1_latency", 32'(lat), 32'd9);
        chk("s1_j",       32'(j_a), 32'(conv(12'h400)));
        tick();
        chk("s1_valid_1cyc", 32'(val_a),  32'h0);
        chk("s1_busy_after", 32'(busy_a), 32'h0);
        chk("s1_idle",       32'(st_a),   32'h0);

        // Ramp 0..3 on sample edges 5..8; other edges carry junk outside the window.
        sum = '0;
        for (int k = 0; k < 4; k++) sum += 14'(conv(12'(k)));
        trig_a = 1'b1;
        adc = 12'hABC;
        tick();
        trig_a = 1'b0;
        seen = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            adc = (e >= 5 && e <= 8) ? 12'(e - 5) : 12'hABC;
            tick();
            if (e < 9) seen |= val_a;
        end
        chk("s2_no_early_valid", 32'(seen), 32'h0);
        chk("s2_valid", 32'(val_a), 32'h1);
        chk("s2_j",     32'(j_a),   32'(sum[13:2]));

        // Overrun: trig during ACCUM, clear, trig in DONE cycle.
        adc = 12'h400;
        start_a();
        for (int e = 1; e <= 5; e++) tick();
        trig_a = 1'b1;
        tick();                      // edge 6
        trig_a = 1'b0;
        chk("s4_ovr_set",      32'(ovr_a), 32'h1);
        chk("s4_still_accum",  32'(st_a),  32'd2);
        clr_a = 1'b1;
        tick();                      // edge 7
        clr_a = 1'b0;
        chk("s4_ovr_clr", 32'(ovr_a), 32'h0);
        tick();                      // edge 8
        trig_a = 1'b1;
        tick();                      // edge 9, DONE->IDLE
        trig_a = 1'b0;
        chk("s4_valid",       32'(val_a), 32'h1);
        chk("s4_j",           32'(j_a),   32'(conv(12'h400)));
        chk("s4_ovr_in_done", 32'(ovr_a), 32'h1);
        tick();
        chk("s4_no_restart", 32'(st_a), 32'h0);
        // Clear and new overrun in the same cycle: set wins.
        start_a();
        clr_a = 1'b1; trig_a = 1'b1;
        tick();
        clr_a = 1'b0; trig_a = 1'b0;
        chk("s4_set_wins", 32'(ovr_a), 32'h1);
        wait_valid(0, 20, lat);
        chk("s4_lat2", 32'(lat), 32'd8);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("s4_clr_pulse", 32'(ovr_a), 32'h0);

        // Abort mid-ACCUM keeps old J.
        adc = 12'h123;
        start_a();
        for (int e = 1; e <= 5; e++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("s5_abort_state", 32'(st_a),   32'h0);
        chk("s5_abort_busy",  32'(busy_a), 32'h0);
        seen = 1'b0;
        for (int e = 0; e < 8; e++) begin tick(); seen |= val_a; end
        chk("s5_abort_novalid", 32'(seen), 32'h0);
        chk("s5_abort_j",       32'(j_a),  32'(conv(12'h400)));
        // Abort beats trigger in IDLE.
        abort_a = 1'b1; trig_a = 1'b1;
        tick();
        abort_a = 1'b0; trig_a = 1'b0;
        chk("s5_abort_wins", 32'(st_a), 32'h0);
        // Asynchronous reset mid-ACCUM.
        start_a();
        for (int e = 1; e <= 6; e++) tick();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_state", 32'(st_a),   32'h0);
        chk("s5_rst_j",     32'(j_a),    32'h0);
        chk("s5_rst_busy",  32'(busy_a), 32'h0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 8; e++) begin tick(); seen |= val_a; end
        chk("s5_rst_novalid", 32'(seen), 32'h0);

        // LOG2_N=8 full scale: no wrap, latency 4+256+1.
        adc = 12'hFFF;
        trig_b = 1'b1;
        tick();
        trig_b = 1'b0;
        wait_valid(1, 300, lat);
        chk("s3_latency", 32'(lat), 32'd261);
        chk("s3_j",       32'(j_b), 32'(conv(12'hFFF)));

        // SETTLE=0, LOG2_N=0: single sample at the edge after the trigger.
        trig_c = 1'b1;
        adc = 12'h111;
        tick();
        trig_c = 1'b0;
        chk("c_state_accum", 32'(st_c), 32'd2);
        adc = 12'h5A5;
        wait_valid(2, 10, lat);
        chk("c_latency", 32'(lat), 32'd2);
        chk("c_j",       32'(j_c), 32'(conv(12'h5A5)));

`ifdef J_AVG_TWOS_COMP_EN
        adc = 12'h800;
        trig_c = 1'b1; tick(); trig_c = 1'b0;
        wait_valid(2, 10, lat);
        chk("tc_min", 32'(j_c), 32'h000);
        adc = 12'h7FF;
        trig_c = 1'b1; tick(); trig_c = 1'b0;
        wait_valid(2, 10, lat);
        chk("tc_max", 32'(j_c), 32'hFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
